// File: rtl/multicycle_control_fsm_if.sv
// Signal bundle between the multi-cycle control unit and the datapath / data memory.
// Memory handshake: MemRead/MemWrite is the request and stays high every MEM cycle until the
// cycle that samples mem_ready=1, which completes the transfer in that same cycle.
interface multicycle_control_fsm_if;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        en;
  logic        Branch;
  logic        RegDst;
  logic        regWrite;
  logic        alu_scr;
  logic [3:0]  alu_op;
  logic        MemToReg;
  logic        MemWrite;
  logic        MemRead;

  modport master (
    input  instruction, zero, mem_ready,
    output en, Branch, RegDst, regWrite, alu_scr, alu_op, MemToReg, MemWrite, MemRead
  );

  modport slave (
    output instruction, zero, mem_ready,
    input  en, Branch, RegDst, regWrite, alu_scr, alu_op, MemToReg, MemWrite, MemRead
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait-state timeout,
// retired-instruction counter and HALT.
module multicycle_control_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  multicycle_control_fsm_if.master bus,
  output logic                     illegal,
  output logic                     mem_error,
  output logic                     halted,
  output logic [CNT_W-1:0]         retired,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_SKIP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_HALT, K_BAD
  } kind_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_err_q, mem_err_d;

  kind_t      kind;
  logic [3:0] dec_aluop;
  logic       dec_regdst, dec_alusrc, dec_mtr;
  logic       sel_active;
  logic       en_c, branch_c, regwrite_c, memread_c, memwrite_c, illegal_c;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^bus.instruction[25:6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Decode works only from the copy latched when leaving FETCH.
  always_comb begin
    kind       = K_BAD;
    dec_aluop  = ALU_AND;
    dec_regdst = 1'b0;
    dec_alusrc = 1'b0;
    dec_mtr    = 1'b0;
    case (op_q)
      6'h00: begin
        kind       = K_R;
        dec_regdst = 1'b1;
        case (funct_q)
          6'h20: dec_aluop = ALU_ADD;
          6'h22: dec_aluop = ALU_SUB;
          6'h24: dec_aluop = ALU_AND;
          6'h25: dec_aluop = ALU_OR;
          6'h27: dec_aluop = ALU_NOR;
          6'h2A: dec_aluop = ALU_SLT;
          default: begin
            kind       = K_BAD;
            dec_regdst = 1'b0;
          end
        endcase
      end
      6'h23: begin
        kind       = K_LW;
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b1;
        dec_mtr    = 1'b1;
      end
      6'h2B: begin
        kind       = K_SW;
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b1;
      end
      6'h04: begin
        kind      = K_BEQ;
        dec_aluop = ALU_SUB;
      end
      6'h08: begin
        kind       = K_ADDI;
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b1;
      end
      6'h3F:   kind = K_HALT;
      default: kind = K_BAD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    mem_err_d  = mem_err_q;
    en_c       = 1'b0;
    branch_c   = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          state_d = S_DECODE;
          op_d    = bus.instruction[31:26];
          funct_d = bus.instruction[5:0];
        end
      end
      S_DECODE: begin
        if (kind == K_HALT) begin
          state_d = S_HALT;
        end else if (kind == K_BAD) begin
          illegal_c = 1'b1;
          state_d   = S_SKIP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_SKIP: begin
        en_c    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC: begin
        if (kind == K_BEQ) begin
          en_c      = 1'b1;
          branch_c  = bus.zero;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (kind == K_LW || kind == K_SW) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        memread_c  = (kind == K_LW);
        memwrite_c = (kind == K_SW);
        if (bus.mem_ready) begin
          if (kind == K_SW) begin
            en_c      = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Last permitted wait cycle without a response: give up on the transfer.
          mem_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        en_c       = 1'b1;
        regwrite_c = 1'b1;
        retired_d  = retired_q + CNT_W'(1);
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign sel_active   = (state_q != S_FETCH) && (state_q != S_HALT);

  assign bus.en       = en_c;
  assign bus.Branch   = branch_c;
  assign bus.regWrite = regwrite_c;
  assign bus.MemRead  = memread_c;
  assign bus.MemWrite = memwrite_c;
  assign bus.RegDst   = sel_active & dec_regdst;
  assign bus.alu_scr  = sel_active & dec_alusrc;
  assign bus.MemToReg = sel_active & dec_mtr;
  assign bus.alu_op   = sel_active ? dec_aluop : 4'b0000;

  assign illegal      = illegal_c;
  assign mem_error    = mem_err_q;
  assign halted       = (state_q == S_HALT);
  assign retired      = retired_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed cases plus random instruction streams checked
// against a per-instruction table of latencies, strobe counts and select values.
module tb_multicycle_control_fsm;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        illegal, mem_error, halted;
  logic [31:0] retired;
  logic [2:0]  dbg_state;

  int          n_total = 0;
  int          n_bad   = 0;
  int          exp_retired = 0;
  logic [31:0] exp_q[$];

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .bus         (bus),
    .illegal     (illegal),
    .mem_error   (mem_error),
    .halted      (halted),
    .retired     (retired),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_strobes"}, {bus.en, bus.Branch, bus.regWrite, bus.MemRead, bus.MemWrite, illegal}, 0);
    chk({tag, "_selects"}, {bus.RegDst, bus.alu_scr, bus.MemToReg, bus.alu_op}, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_status"}, {halted, mem_error}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    bus.instruction = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    exp_retired = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #2 check_outputs_idle("reset");
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 run = 1'b0;
      #3 chk("stall_en", {bus.en, bus.MemRead, bus.MemWrite}, 0);
    end
  endtask

  task automatic check_retired();
    if (exp_q.size() > 0) chk("retired", retired, exp_q.pop_front());
  endtask

  // Runs one instruction starting in FETCH and compares its whole trace with the expected table.
  task automatic run_instr(input logic [31:0] ins, input int waits, input logic zv);
    logic [5:0] op, fn;
    logic [3:0] alu;
    logic       r_ok, e_br, e_merr, br, done;
    logic [6:0] e_sel, sel_fetch, sel_dec, sel_end;
    int e_lat, e_halt, e_mr, e_mw, e_rw, e_ill, e_inc;
    int cyc, lat, halt_cyc, mr, mw, rw, enc, ilc, viol;

    op = ins[31:26];
    fn = ins[5:0];
    e_lat = 0; e_halt = 0; e_mr = 0; e_mw = 0; e_rw = 0; e_ill = 0; e_inc = 0;
    e_br = 1'b0; e_merr = 1'b0; e_sel = '0; alu = 4'b0000; r_ok = 1'b1;
    if (op == 6'h00) begin
      case (fn)
        6'h20: alu = 4'b0010;
        6'h22: alu = 4'b0110;
        6'h24: alu = 4'b0000;
        6'h25: alu = 4'b0001;
        6'h27: alu = 4'b1100;
        6'h2A: alu = 4'b0111;
        default: r_ok = 1'b0;
      endcase
      if (r_ok) begin
        e_sel = {3'b100, alu}; e_lat = 4; e_rw = 1; e_inc = 1;
      end else begin
        e_ill = 1; e_lat = 3;
      end
    end else begin
      case (op)
        6'h23: begin
          e_sel = 7'b011_0010;
          if (waits < WAIT_MAX) begin
            e_lat = 5 + waits; e_mr = waits + 1; e_rw = 1; e_inc = 1;
          end else begin
            e_halt = 4 + WAIT_MAX; e_mr = WAIT_MAX; e_merr = 1'b1;
          end
        end
        6'h2B: begin
          e_sel = 7'b010_0010;
          if (waits < WAIT_MAX) begin
            e_lat = 4 + waits; e_mw = waits + 1; e_inc = 1;
          end else begin
            e_halt = 4 + WAIT_MAX; e_mw = WAIT_MAX; e_merr = 1'b1;
          end
        end
        6'h04: begin
          e_sel = 7'b000_0110; e_lat = 3; e_br = zv; e_inc = 1;
        end
        6'h08: begin
          e_sel = 7'b010_0010; e_lat = 4; e_rw = 1; e_inc = 1;
        end
        6'h3F: e_halt = 3;
        default: begin
          e_ill = 1; e_lat = 3;
        end
      endcase
    end

    cyc = 0; lat = 0; halt_cyc = 0; mr = 0; mw = 0; rw = 0; enc = 0; ilc = 0; viol = 0;
    br = 1'b0; done = 1'b0; sel_fetch = '0; sel_dec = '0; sel_end = '0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      run = (cyc == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.instruction = ins;
      bus.zero = zv;
      bus.mem_ready = (cyc >= 4 + waits);
      #3;
      if (cyc == 1) begin
        sel_fetch = {bus.RegDst, bus.alu_scr, bus.MemToReg, bus.alu_op};
        check_retired();
      end
      if (cyc == 2) sel_dec = {bus.RegDst, bus.alu_scr, bus.MemToReg, bus.alu_op};
      mr  += int'(bus.MemRead);
      mw  += int'(bus.MemWrite);
      rw  += int'(bus.regWrite);
      enc += int'(bus.en);
      ilc += int'(illegal);
      if (bus.Branch && !bus.en) viol++;
      if (bus.MemRead && bus.MemWrite) viol++;
      if (bus.en) begin
        lat = cyc;
        br = bus.Branch;
        sel_end = {bus.RegDst, bus.alu_scr, bus.MemToReg, bus.alu_op};
        done = 1'b1;
      end
      if (halted) begin
        halt_cyc = cyc;
        done = 1'b1;
      end
    end

    chk("latency", lat, e_lat);
    chk("halt_cycle", halt_cyc, e_halt);
    chk("memread_cycles", mr, e_mr);
    chk("memwrite_cycles", mw, e_mw);
    chk("regwrite_count", rw, e_rw);
    chk("en_count", enc, (e_lat != 0) ? 1 : 0);
    chk("illegal_count", ilc, e_ill);
    chk("branch", br, e_br);
    chk("strobe_rules", viol, 0);
    chk("sel_fetch", sel_fetch, 0);
    chk("sel_decode", sel_dec, e_sel);
    if (e_lat != 0) chk("sel_end", sel_end, e_sel);
    chk("mem_error", mem_error, e_merr);
    exp_retired += e_inc;
    exp_q.push_back(32'(exp_retired));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [25:0] body;
    logic [5:0]  fn;
    body = 26'($urandom);
    fn = 6'h20;
    case ($urandom_range(0, 9))
      0, 1: begin
        case ($urandom_range(0, 5))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          4: fn = 6'h27;
          default: fn = 6'h2A;
        endcase
        return {6'h00, body[25:6], fn};
      end
      2, 9: return {6'h23, body};
      3:    return {6'h2B, body};
      4, 5: return {6'h04, body};
      6:    return {6'h08, body};
      7:    return {($urandom_range(0, 1) == 0) ? 6'h3E : 6'h01, body};
      default: return {6'h00, body[25:6], 6'h21};
    endcase
  endfunction

  initial begin
    do_reset();

    // Directed cases from the test plan plus the wait-count boundary that still completes.
    run_instr(32'h00221820, 0, 1'b0);
    run_instr(32'h8C230004, 3, 1'b0);
    run_instr(32'h10220003, 0, 1'b1);
    run_instr(32'h10220003, 0, 1'b0);
    run_instr(32'h8C230004, WAIT_MAX - 1, 1'b0);
    run_instr(32'hAC230000, WAIT_MAX - 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      stall($urandom_range(0, 2));
      run_instr(rand_instr(), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    stall(1);
    check_retired();

    // Reset in the middle of a store's MEM phase.
    do_reset();
    @(posedge clk);
    #1 run = 1'b1;
    bus.instruction = 32'hAC230000;
    bus.mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #3 chk("rst_pre_memwrite", bus.MemWrite, 1);
    #1 rst = 1'b0;
    #1 chk("rst_async_memwrite", bus.MemWrite, 0);
    chk("rst_async_en", bus.en, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    run = 1'b0;
    #2 check_outputs_idle("rst_mid_mem");

    // Illegal opcode, then HALT which must hold until reset.
    exp_retired = 0;
    exp_q.delete();
    run_instr(32'hF8000000, 0, 1'b0);
    run_instr(32'hFC000000, 0, 1'b0);
    begin
      int halt_cnt, strobe_cnt;
      halt_cnt = 0;
      strobe_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1 run = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #3;
        halt_cnt += int'(halted);
        strobe_cnt += int'(bus.en) + int'(bus.regWrite) + int'(bus.MemRead) + int'(bus.MemWrite);
      end
      chk("halt_hold", halt_cnt, 20);
      chk("halt_strobes", strobe_cnt, 0);
    end
    check_retired();
    chk("halt_retired_zero", retired, 0);

    // Store that never completes: timeout, mem_error, halt, retired unchanged.
    do_reset();
    run_instr(32'h00221820, 0, 1'b0);
    stall(1);
    check_retired();
    run_instr(32'hAC230000, WAIT_MAX, 1'b0);
    stall(3);
    check_retired();
    chk("timeout_halted", halted, 1);
    chk("timeout_mem_error_sticky", mem_error, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit that drives the control inputs of the datapath top: en, Branch, RegDst, regWrite, alu_scr, alu_op, MemToReg, MemWrite and MemRead.
- Consumes the instruction word and the ALU zero flag from the datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a wait-state handshake to data memory.
- Counts retired instructions and halts on the HALT opcode or a memory timeout.

Parameters:
WAIT_MAX, 15, max cycles spent in MEM waiting for mem_ready before timeout (1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
run  input  1  permits leaving FETCH; low = stall before the next instruction
instruction  input  32  current instruction word from instruction memory
zero  input  1  ALU result == 0, from the datapath
mem_ready  input  1  data memory has completed the current read/write
en  output  1  PC update strobe (one cycle per retired instruction)
Branch  output  1  selects branch target; valid only while en=1
RegDst  output  1  1 = rd, 0 = rt as write register
regWrite  output  1  register-file write strobe
alu_scr  output  1  1 = sign-extended immediate as ALU B
alu_op  output  4  ALU operation code
MemToReg  output  1  1 = memory data to the register write port
MemWrite  output  1  data memory write request
MemRead  output  1  data memory read request
illegal  output  1  one-cycle pulse on an unsupported opcode/funct
mem_error  output  1  sticky; set on memory timeout
halted  output  1  high while in HALT
retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (rst=0, async): state=FETCH; all outputs 0; retired=0; wait counter=0; mem_error=0.
- Opcode and funct are latched into internal registers on the FETCH->DECODE transition. All decode uses the latched copy, since instruction is stable until en.
- ALU codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- Supported instructions:
  - R-type (op 0x00) with funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04 (ALU=SUB), addi 0x08 (ALU=ADD), HALT 0x3F.
- Select outputs (RegDst, alu_scr, alu_op, MemToReg) are 0 in FETCH. From DECODE until the end of the instruction they hold the decoded value.
  - R-type: RegDst=1, alu_scr=0.
  - lw: alu_scr=1, MemToReg=1.
  - sw / addi: alu_scr=1.
- State transitions:
  - FETCH: if run=1, go to DECODE; otherwise stay.
  - DECODE: HALT -> HALT. Unsupported -> pulse illegal and go to SKIP. Otherwise -> EXEC.
  - SKIP: en=1 for one cycle (PC+4, no writes); retired is not incremented; -> FETCH.
  - EXEC:
    - R-type/addi -> WB; lw/sw -> MEM.
    - beq: en=1 and Branch=zero in this cycle; retired+1; -> FETCH.
  - MEM:
    - MemRead (lw) or MemWrite (sw) is held high every cycle in MEM; the wait counter increments each cycle mem_ready=0.
    - mem_ready=1, lw: drop the request and go to WB.
    - mem_ready=1, sw: en=1 in that same cycle, MemWrite stays high, retired+1, -> FETCH.
    - Counter reaches WAIT_MAX with mem_ready=0: drop the request, set mem_error, -> HALT. en is not asserted.
  - WB: regWrite=1 and en=1 for exactly one cycle; retired+1; -> FETCH.
  - HALT: every strobe is 0; halted=1. Exit only via reset.
- Latency (mem_ready already high on the first MEM cycle):
  - R-type/addi: 4 cycles; beq: 3; sw: 4; lw: 5.
  - Each memory wait cycle adds 1.
- Strobe rules:
  - en, regWrite and Branch are never high outside the cycles listed above.
  - Branch=1 implies en=1.
  - MemRead and MemWrite are never both high.
- The wait counter clears on MEM entry. retired wraps modulo 2^CNT_W.
- run is sampled only in FETCH. Dropping run mid-instruction does not stall it.
- Reset asserted mid-MEM: requests drop immediately (async) and the pending write is abandoned.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820), run=1 -> DECODE..WB spans 4 cycles; RegDst=1, alu_op=0010; en and regWrite each pulse once in cycle 4; retired=1.
- lw 0x8C230004 with mem_ready low 3 cycles then high -> MemRead high for 4 cycles, MemToReg=1, alu_scr=1; WB pulses regWrite; total 8 cycles.
- beq 0x10220003 with zero=1, then again with zero=0 -> en in EXEC both times; Branch=1 only in the first case; regWrite never asserted.
- sw 0xAC230000 with mem_ready stuck 0, WAIT_MAX=15 -> MemWrite high for 15 cycles, then mem_error=1 and halted=1; en never pulses; retired unchanged.
- Opcode 0x3E, then HALT 0xFC000000 -> illegal pulses once; SKIP gives one en with no regWrite; HALT holds halted=1 forever; retired=0.
- rst pulled low mid-MEM of an sw -> MemWrite falls with no clock edge; after release, state=FETCH and retired=0.
